// File: rtl/mem_stage.sv
// Memory pipeline stage: it accepts one instruction, performs its load or store over a
// request/response port, aligns the load data and hands the GPR write to write-back.
module mem_stage #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_ebreak_i,
  input  logic [ADDR_WIDTH-1:0] in_rd_i,
  input  logic                  in_rd_en_i,
  input  logic [31:0]           in_gpr_wdata_i,
  input  logic                  in_lsu_ren_i,
  input  logic                  in_lsu_wen_i,
  input  logic [3:0]            in_lsu_mask_i,
  input  logic                  in_lsu_signed_i,
  input  logic [31:0]           in_lsu_addr_i,
  input  logic [31:0]           in_lsu_wdata_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic                  mem_req_wen_o,
  output logic [31:0]           mem_req_addr_o,
  output logic [31:0]           mem_req_wdata_o,
  output logic [3:0]            mem_req_wstrb_o,
  input  logic                  mem_resp_valid_i,
  input  logic [31:0]           mem_resp_rdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_ebreak_o,
  output logic [ADDR_WIDTH-1:0] out_rd_o,
  output logic                  out_rd_en_o,
  output logic [31:0]           out_wdata_o,
  output logic                  fwd_wen_o,
  output logic                  fwd_wvalid_o,
  output logic [ADDR_WIDTH-1:0] fwd_waddr_o,
  output logic [31:0]           fwd_wdata_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t state, state_next;

  logic                  ebreak_q, rd_en_q, ren_q, wen_q, signed_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [31:0]           gpr_wdata_q, addr_q, wdata_q, result_q;
  logic [3:0]            mask_q;

  logic        in_fire, out_fire, req_fire, resp_fire, in_is_mem;
  logic [4:0]  lane_shamt;
  logic [31:0] load_raw, load_data;

  assign out_fire   = out_valid_o & out_ready_i;
  assign in_fire    = in_valid_i & in_ready_o;
  assign req_fire   = mem_req_valid_o & mem_req_ready_i;
  assign resp_fire  = (state == RESP) & mem_resp_valid_i;
  assign in_is_mem  = in_lsu_ren_i | in_lsu_wen_i;
  assign lane_shamt = {addr_q[1:0], 3'b000};

  // State register.
  // NOTE: Sequential state uses non-blocking assignments only. Blocking assignments here
  // would let one always_ff read another's value from the same edge in simulation.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  // NOTE: state_next is defaulted first so that no path through the case infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_fire) state_next = in_is_mem ? REQ : DONE;
      REQ:     if (req_fire) state_next = RESP;
      RESP:    if (mem_resp_valid_i) state_next = DONE;
      DONE: begin
        if (in_fire)       state_next = in_is_mem ? REQ : DONE;
        else if (out_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic. This is a combinational function of the state and the latched payload,
  // so the request and result fields cannot change while their valid is held.
  always_comb begin
    in_ready_o      = (state == IDLE) | ((state == DONE) & out_ready_i);
    mem_req_valid_o = (state == REQ);
    out_valid_o     = (state == DONE);
    fwd_wen_o       = rd_en_q & (state != IDLE);
    fwd_wvalid_o    = rd_en_q & (state == DONE);
  end

  assign mem_req_wen_o   = wen_q;
  assign mem_req_addr_o  = {addr_q[31:2], 2'b00};
  assign mem_req_wdata_o = wdata_q << lane_shamt;
  assign mem_req_wstrb_o = wen_q ? (mask_q << addr_q[1:0]) : 4'b0000;

  // Load alignment. Bytes shifted in from beyond bit 31 are zero on misaligned loads.
  assign load_raw = mem_resp_rdata_i >> lane_shamt;
  always_comb begin
    load_data = load_raw;
    if (mask_q == 4'b0001)
      load_data = {{24{signed_q & load_raw[7]}}, load_raw[7:0]};
    else if (mask_q == 4'b0011)
      load_data = {{16{signed_q & load_raw[15]}}, load_raw[15:0]};
  end

  // Payload registers. When both load and store are set, the store wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ebreak_q    <= 1'b0;
      rd_q        <= '0;
      rd_en_q     <= 1'b0;
      gpr_wdata_q <= '0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      mask_q      <= '0;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      result_q    <= '0;
    end else if (in_fire) begin
      ebreak_q    <= in_ebreak_i;
      rd_q        <= in_rd_i;
      rd_en_q     <= in_rd_en_i;
      gpr_wdata_q <= in_gpr_wdata_i;
      ren_q       <= in_lsu_ren_i & ~in_lsu_wen_i;
      wen_q       <= in_lsu_wen_i;
      mask_q      <= in_lsu_mask_i;
      signed_q    <= in_lsu_signed_i;
      addr_q      <= in_lsu_addr_i;
      wdata_q     <= in_lsu_wdata_i;
      result_q    <= in_gpr_wdata_i;
    end else if (resp_fire) begin
      result_q    <= ren_q ? load_data : gpr_wdata_q;
    end
  end

  assign out_ebreak_o = ebreak_q;
  assign out_rd_o     = rd_q;
  assign out_rd_en_o  = rd_en_q;
  assign out_wdata_o  = result_q;
  assign fwd_waddr_o  = rd_q;
  assign fwd_wdata_o  = result_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Accepts one instruction per handshake: ALU/CSR result, LSU controls, address and store data.
- Performs the load or store over a simple request/response memory port, then aligns and sign-extends load data.
- Presents the final GPR write to write-back and drives a forwarding port for the decode/issue stage.

Parameters:
- ADDR_WIDTH, 4, width of the register index (rd).

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- in_valid_i  in  1  upstream valid
- in_ready_o  out  1  stage can accept
- in_ebreak_i  in  1  ebreak marker
- in_rd_i  in  ADDR_WIDTH  destination register
- in_rd_en_i  in  1  destination write enable
- in_gpr_wdata_i  in  32  non-load result
- in_lsu_ren_i  in  1  load
- in_lsu_wen_i  in  1  store
- in_lsu_mask_i  in  4  size mask: 0001 byte, 0011 half, 1111 word
- in_lsu_signed_i  in  1  sign-extend load
- in_lsu_addr_i  in  32  byte address
- in_lsu_wdata_i  in  32  store data, LSB-aligned
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_req_wen_o  out  1  1 = write
- mem_req_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_req_wdata_o  out  32  lane-shifted store data
- mem_req_wstrb_o  out  4  byte strobes
- mem_resp_valid_i  in  1  response (read data or write ack)
- mem_resp_rdata_i  in  32  read word
- out_valid_o  out  1  result valid to write-back
- out_ready_i  in  1  write-back accepts
- out_ebreak_o  out  1  ebreak marker
- out_rd_o  out  ADDR_WIDTH  destination
- out_rd_en_o  out  1  write enable
- out_wdata_o  out  32  final GPR data
- fwd_wen_o  out  1  stage holds an instruction writing rd
- fwd_wvalid_o  out  1  fwd_wdata_o is final
- fwd_waddr_o  out  ADDR_WIDTH  = rd
- fwd_wdata_o  out  32  = out_wdata_o

Behaviour:

Reset:
- State IDLE; out_valid_o, mem_req_valid_o, fwd_wen_o and fwd_wvalid_o are 0.
- All payload registers are 0.

State machine (IDLE, REQ, RESP, DONE):
- in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- in_ready_o = (state==IDLE) | (state==DONE & out_fire).
- On in_fire, all inputs are latched. Next state is REQ if ren|wen, otherwise DONE with result = gpr_wdata.
- REQ: mem_req_valid_o = 1, held with address, data and strobes stable until mem_req_ready_i. When the request fires, go to RESP.
- RESP: wait for mem_resp_valid_i.
  - Load: capture the aligned/extended data as the result.
  - Store: result = latched gpr_wdata.
  - Go to DONE.
- mem_resp_valid_i in the same cycle as the request fire is not allowed; the response is sampled only in RESP.
- DONE: out_valid_o = 1.
  - out_fire with no in_fire: go to IDLE.
  - out_fire with simultaneous in_fire: load the new instruction, next state per its type (back-to-back, no bubble).
- Minimum latency (cycles, in_fire to out_valid_o):
  - Non-memory instruction: 1.
  - Memory op with ready=1 and resp one cycle later: 3.

Lane/width rules (o = addr[1:0]):
- wstrb = (mask << o) truncated to 4 bits.
- wdata = wdata_i << (8*o).
- Load raw = rdata >> (8*o).
  - mask 0001: byte raw[7:0], extended by raw[7] if signed, else zero.
  - mask 0011: half raw[15:0], extended by raw[15] if signed, else zero.
  - mask 1111: word.
- Misaligned accesses are not trapped. Strobes are truncated and data bits shifted past bit 31 are dropped.
- Loads issue wen=0, wstrb=0000.
- Simultaneous ren and wen is illegal; wen takes priority.

Forwarding:
- fwd_wen_o = rd_en & (state!=IDLE).
- fwd_wvalid_o = rd_en & (state==DONE).
- A load in REQ/RESP therefore reports wen=1 and wvalid=0, so upstream stalls.

Out-side outputs:
- out_* payload is stable while out_valid_o=1 and out_ready_i=0.
- out_valid_o never drops without out_fire.

Reset mid-operation:
- Returns to IDLE next cycle; any outstanding request is abandoned and mem_req_valid_o drops.
- The memory side must tolerate this.

Test Plan:
- ALU op: rd=5, gpr_wdata=0x1234, no LSU, out_ready=1 -> out_valid one cycle after in_fire, out_wdata=0x1234, fwd_wvalid=1; in_ready=1 in that same cycle.
- Signed byte load: addr=0x80000003, mask=0001, signed=1, rdata=0x80FFFFFF -> req_addr=0x80000000, wstrb=0000, out_wdata=0xFFFFFF80; unsigned variant -> 0x00000080.
- Half store: addr=0x10000002, mask=0011, wdata=0x0000BEEF -> req_wen=1, wstrb=1100, req_wdata=0xBEEF0000; done after ack, out_wdata=gpr_wdata.
- Backpressure: mem_req_ready=0 for 5 cycles, then out_ready=0 for 3 cycles -> request fields and outputs stable throughout, in_ready=0, fwd_wen=1 with fwd_wvalid=0 until DONE.
- Back-to-back: two ALU ops with continuous valid and out_ready=1 -> one result per cycle, no bubble.
- Reset asserted while in RESP -> next cycle out_valid=0, mem_req_valid=0, in_ready=1.
